// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM sequencer for VGA scanout with a shared CPU port.
// Display fetches run one pixel block ahead of the beam and always win.
// The CPU gets any remaining RAM cycle through a req/ack handshake.
module vga_fb_scheduler #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = H_ACTIVE >> SCALE_SHIFT,
    parameter int ADDR_W      = 15,
    parameter int PIX_W       = 8
) (
    input  logic              clock_25mhz,
    input  logic              reset_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic [PIX_W-1:0]  pixel,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [PIX_W-1:0]  cpu_wdata,
    output logic              cpu_ack,
    output logic [PIX_W-1:0]  cpu_rdata
);

    localparam int BLK = 1 << SCALE_SHIFT;

    // Phase within a block at which the fetch is issued / the pixel is loaded.
    localparam logic [SCALE_SHIFT-1:0] PH_SLOT = SCALE_SHIFT'(BLK - 2);
    localparam logic [SCALE_SHIFT-1:0] PH_LOAD = SCALE_SHIFT'(BLK - 1);

    localparam logic [9:0] X_WRAP_SLOT = 10'(H_TOTAL - 2);
    localparam logic [9:0] X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state;
    logic   op_read;

    logic [9:0]        next_line;
    logic [9:0]        tgt_col;
    logic [9:0]        tgt_line;
    logic              tgt_vis;
    logic              slot;
    logic              load_vis;
    logic              grant;
    logic [ADDR_W-1:0] slot_addr;

    // Line the beam moves to after the current one, wrapping at end of frame.
    assign next_line = (y == Y_LAST) ? 10'd0 : y + 10'd1;

    // Block targeted by a fetch issued now: two columns ahead, wrapping to column 0 of the next line.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        tgt_col  = '0;
        tgt_line = '0;
        tgt_vis  = 1'b0;
        if (x == X_WRAP_SLOT) begin
            tgt_col  = '0;
            tgt_line = next_line;
            tgt_vis  = (next_line < V_ACT);
        end else begin
            tgt_col  = x + 10'd2;
            tgt_line = y;
            tgt_vis  = (x + 10'd2 < H_ACT) && (y < V_ACT);
        end
    end

    assign slot      = (x[SCALE_SHIFT-1:0] == PH_SLOT) && tgt_vis;
    assign slot_addr = ADDR_W'(tgt_line >> SCALE_SHIFT) * ADDR_W'(FB_W)
                     + ADDR_W'(tgt_col >> SCALE_SHIFT);

    // Block starting on the next cycle: one column ahead, or column 0 of the next line.
    assign load_vis = (x == X_LAST) ? (next_line < V_ACT)
                                    : ((x + 10'd1 < H_ACT) && (y < V_ACT));

    // CPU may use the RAM only in a free cycle while idle and out of reset.
    assign grant = (state == S_IDLE) && cpu_req && !slot && reset_n;

    // RAM port mux: display fetch first, then CPU grant, otherwise parked at zero.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (slot) begin
            ram_addr = slot_addr;
        end else if (grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // CPU handshake FSM: grant, collect read data one cycle later, then pulse ack.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_read   <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state   <= S_WAIT;
                        op_read <= !cpu_we;
                    end
                end
                S_WAIT: begin
                    if (op_read) cpu_rdata <= ram_rdata;
                    cpu_ack <= 1'b1;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel register: load fetched block data on the last cycle of each block, blank otherwise.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            pixel <= '0;
        end else if (x[SCALE_SHIFT-1:0] == PH_LOAD) begin
            pixel <= load_vis ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler: bench-side beam generator and RAM,
// a linear-position reference model checked every cycle, plus literal pins.
module tb_vga_fb_scheduler;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int SCALE_SHIFT = 2;
    localparam int BLK         = 4;
    localparam int FB_W        = 160;
    localparam int ADDR_W      = 15;
    localparam int PIX_W       = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [PIX_W-1:0]  ram_wdata;
    logic [PIX_W-1:0]  ram_rdata;
    logic [PIX_W-1:0]  pixel;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [PIX_W-1:0]  cpu_wdata;
    logic              cpu_ack;
    logic [PIX_W-1:0]  cpu_rdata;

    vga_fb_scheduler #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .SCALE_SHIFT(SCALE_SHIFT), .FB_W(FB_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
    ) dut (
        .clock_25mhz(clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pixel      (pixel),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (x=%0d y=%0d)", name, act, exp, x, y);
        end
    endtask

    // Single-port RAM, synchronous read, preloaded with mem[a] = a[7:0].
    logic [7:0] mem [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = i[7:0];
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model, expressed on the linear beam position within a frame.
    function automatic bit model_slot(input int xx, input int yy, output int addr);
        int p, tx, ty;
        p    = (yy * H_TOTAL + xx + 2) % (H_TOTAL * V_TOTAL);
        tx   = p % H_TOTAL;
        ty   = p / H_TOTAL;
        addr = (ty / BLK) * FB_W + tx / BLK;
        return (tx % BLK == 0) && (tx < H_ACTIVE) && (ty < V_ACTIVE);
    endfunction

    function automatic logic [7:0] exp_pix(input int xx, input int yy);
        if (xx < H_ACTIVE && yy < V_ACTIVE) return mem[(yy / BLK) * FB_W + xx / BLK];
        return 8'h00;
    endfunction

    // Literal expectations keyed by y*H_TOTAL+x, each checked once when the beam gets there.
    logic [7:0]        lit_pix  [int];
    logic [ADDR_W-1:0] lit_addr [int];

    int         consec = 0;
    int         cyc = 0;
    bit         m_busy = 0;
    bit         m_read = 0;
    int         m_ack_cyc = 0;
    logic [7:0] m_rexp = '0;
    logic [7:0] m_rdata = '0;
    bit         prev_ack = 0;
    int         last_we_x = -1;
    int         ack_count = 0;
    int         c_key, c_sa;
    bit         c_slot, c_grant, c_exp_ack;

    // Compare process: checks every DUT output against the model each cycle.
    always @(negedge clk) begin
        cyc++;
        c_key = int'(y) * H_TOTAL + int'(x);
        if (!reset_n) begin
            check("rst_ram_we", ram_we, 0);
            check("rst_pixel", pixel, 0);
            check("rst_cpu_ack", cpu_ack, 0);
            check("rst_cpu_rdata", cpu_rdata, 0);
            m_busy  = 0;
            m_rdata = '0;
        end else begin
            c_slot    = model_slot(int'(x), int'(y), c_sa);
            c_grant   = !m_busy && cpu_req && !c_slot;
            c_exp_ack = m_busy && (cyc == m_ack_cyc);
            if (c_exp_ack && m_read) m_rdata = m_rexp;
            check("cpu_ack", cpu_ack, c_exp_ack);
            check("cpu_rdata", cpu_rdata, m_rdata);
            check("ack_double", prev_ack && cpu_ack, 0);
            if (c_slot) begin
                check("slot_addr", ram_addr, c_sa);
                check("slot_we", ram_we, 0);
            end else if (c_grant) begin
                check("grant_addr", ram_addr, cpu_addr);
                check("grant_we", ram_we, cpu_we);
                if (cpu_we) check("grant_wdata", ram_wdata, cpu_wdata);
            end else begin
                check("idle_addr", ram_addr, 0);
                check("idle_we", ram_we, 0);
            end
            if (c_grant) begin
                m_busy    = 1;
                m_read    = !cpu_we;
                m_ack_cyc = cyc + 2;
                m_rexp    = mem[cpu_addr];
            end else if (c_exp_ack) begin
                m_busy = 0;
            end
            if (consec >= 8) check("pixel", pixel, exp_pix(int'(x), int'(y)));
            if (lit_pix.exists(c_key)) begin
                check($sformatf("lit_pix@%0d,%0d", x, y), pixel, lit_pix[c_key]);
                lit_pix.delete(c_key);
            end
            if (lit_addr.exists(c_key)) begin
                check($sformatf("lit_addr@%0d,%0d", x, y), ram_addr, lit_addr[c_key]);
                lit_addr.delete(c_key);
            end
            if (ram_we) last_we_x = int'(x);
        end
        if (cpu_ack) ack_count++;
        prev_ack = cpu_ack;
    end

    // Beam generator helpers: advance one pixel, or jump to a new position.
    task automatic step();
        @(posedge clk);
        #1;
        if (int'(x) == H_TOTAL - 1) begin
            x = '0;
            y = (int'(y) == V_TOTAL - 1) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        consec++;
    endtask

    task automatic jump(input int nx, input int ny);
        @(posedge clk);
        #1;
        x      = 10'(nx);
        y      = 10'(ny);
        consec = 0;
    endtask

    task automatic walk_to(input int nx, input int ny);
        int n;
        n = 0;
        while (!(int'(x) == nx && int'(y) == ny) && n < 2000) begin
            step();
            n++;
        end
        check($sformatf("walk_reached_%0d_%0d", nx, ny), (int'(x) == nx && int'(y) == ny), 1);
    endtask

    task automatic wait_ack(input int budget, output int ax);
        ax = -1;
        for (int i = 0; i < budget; i++) begin
            if (cpu_ack) begin
                ax = int'(x);
                return;
            end
            step();
        end
    endtask

    function automatic int key(input int xx, input int yy);
        return yy * H_TOTAL + xx;
    endfunction

    int ax;
    int ack_x [8];
    int saved_acks;

    initial begin
        reset_n   = 1'b0;
        x         = '0;
        y         = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        x       = 10'd790;
        y       = 10'd524;
        consec  = 0;

        // Line 0 scanout across the frame boundary.
        for (int i = 0; i < 4; i++) lit_pix[key(i, 0)] = 8'h00;
        for (int i = 4; i < 8; i++) lit_pix[key(i, 0)] = 8'h01;
        for (int i = 636; i < 640; i++) lit_pix[key(i, 0)] = 8'h9F;
        lit_pix[key(640, 0)] = 8'h00;
        lit_pix[key(700, 0)] = 8'h00;
        lit_pix[key(799, 0)] = 8'h00;
        lit_addr[key(798, 524)] = 15'd0;
        lit_addr[key(2, 0)]     = 15'd1;
        lit_addr[key(634, 0)]   = 15'd159;
        walk_to(799, 0);

        // Line 4 starts the second framebuffer row.
        jump(790, 3);
        for (int i = 0; i < 4; i++) lit_pix[key(i, 4)] = 8'hA0;
        lit_addr[key(798, 3)] = 15'd160;
        walk_to(8, 4);

        // No fetch after the last visible line; vertical blanking stays dark.
        jump(780, 479);
        lit_addr[key(798, 479)] = 15'd0;
        lit_pix[key(0, 480)]    = 8'h00;
        lit_pix[key(100, 480)]  = 8'h00;
        walk_to(120, 480);
        jump(780, 523);
        walk_to(10, 0);

        // CPU write of 0x3C to address 5, request raised in a free cycle.
        jump(90, 10);
        walk_to(100, 10);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 8'h3C;
        wait_ack(10, ax);
        check("wr_ack_x", ax, 102);
        check("wr_grant_x", last_we_x, 100);
        step();
        cpu_req = 1'b0;

        // CPU write of 0x55 to address 0, visible at the top-left block.
        walk_to(120, 10);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd0; cpu_wdata = 8'h55;
        wait_ack(10, ax);
        check("wr0_ack_x", ax, 122);
        step();
        cpu_req = 1'b0;

        // Next frame shows both writes.
        jump(790, 524);
        for (int i = 0; i < 4; i++) lit_pix[key(i, 0)] = 8'h55;
        lit_pix[key(4, 0)]  = 8'h01;
        lit_pix[key(20, 0)] = 8'h3C;
        lit_pix[key(23, 0)] = 8'h3C;
        lit_pix[key(24, 0)] = 8'h06;
        walk_to(30, 0);

        // CPU read raised in a slot cycle: grant slips one cycle.
        jump(95, 10);
        walk_to(102, 10);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        wait_ack(10, ax);
        check("rd_ack_x", ax, 105);
        check("rd_rdata", cpu_rdata, 8'h34);
        step();
        cpu_req = 1'b0;
        repeat (5) step();
        check("rd_rdata_hold", cpu_rdata, 8'h34);

        // Back-to-back reads with req held high.
        jump(200, 20);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd300;
        for (int i = 0; i < 8; i++) begin
            wait_ack(10, ack_x[i]);
            check($sformatf("b2b_ack_seen_%0d", i), ack_x[i] >= 0, 1);
            step();
            cpu_addr = 15'(300 + 7 * (i + 1));
        end
        cpu_req = 1'b0;
        check("b2b_ack0_x", ack_x[0], 202);
        check("b2b_ack1_x", ack_x[1], 205);
        check("b2b_ack2_x", ack_x[2], 209);
        check("b2b_ack7_x", ack_x[7], 229);
        repeat (4) step();

        // Reset asserted during WAIT of a write abandons the transaction.
        jump(90, 30);
        walk_to(100, 30);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd777; cpu_wdata = 8'hEE;
        saved_acks = ack_count;
        step();
        reset_n = 1'b0;
        repeat (3) step();
        step();
        reset_n = 1'b1;
        consec  = 0;
        check("rst_no_ack", ack_count, saved_acks);
        wait_ack(10, ax);
        check("post_rst_ack_x", ax, 107);
        step();
        cpu_req = 1'b0;
        repeat (10) step();

        check("lit_all_reached", lit_pix.num() + lit_addr.num(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
